// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into register-write commands [SYNC, ADDR, DHI, DLO, (CHK)].
// Define CMD_PARSER_CHKSUM_EN for the 5-byte checksummed frame; otherwise frames are 4 bytes.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 50000,
  parameter int         TO_SIZE      = $clog2(TIMEOUT_CLKS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic        busy
);

`ifdef CMD_PARSER_CHKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DHI, S_DLO, S_CHK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DHI, S_DLO} state_e;
`endif

  state_e               state_q, state_d;
  logic [7:0]           addr_sh_q, addr_sh_d;
  logic [7:0]           dhi_sh_q, dhi_sh_d;
`ifdef CMD_PARSER_CHKSUM_EN
  logic [7:0]           dlo_sh_q, dlo_sh_d;
`endif
  logic [TO_SIZE-1:0]   to_cnt_q, to_cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [7:0]           wr_addr_q, wr_addr_d;
  logic [15:0]          wr_data_q, wr_data_d;
  logic                 frame_err_q, frame_err_d;
  logic [7:0]           err_count_q, err_count_d;

  // NOTE: every sequential assignment is non-blocking so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: shadow bytes are always written before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_sh_q <= addr_sh_d;
    dhi_sh_q  <= dhi_sh_d;
`ifdef CMD_PARSER_CHKSUM_EN
    dlo_sh_q  <= dlo_sh_d;
`endif
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    addr_sh_d   = addr_sh_q;
    dhi_sh_d    = dhi_sh_q;
`ifdef CMD_PARSER_CHKSUM_EN
    dlo_sh_d    = dlo_sh_q;
`endif
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;

    if (state_q == S_IDLE || rx_valid) to_cnt_d = '0;
    else                               to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = S_ADDR;
      S_ADDR: if (rx_valid) begin
        addr_sh_d = rx_data;
        state_d   = S_DHI;
      end
      S_DHI: if (rx_valid) begin
        dhi_sh_d = rx_data;
        state_d  = S_DLO;
      end
`ifdef CMD_PARSER_CHKSUM_EN
      S_DLO: if (rx_valid) begin
        dlo_sh_d = rx_data;
        state_d  = S_CHK;
      end
      S_CHK: if (rx_valid) begin
        if (rx_data == (addr_sh_q ^ dhi_sh_q ^ dlo_sh_q)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_sh_q;
          wr_data_d = {dhi_sh_q, dlo_sh_q};
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
`else
      S_DLO: if (rx_valid) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_sh_q;
        wr_data_d = {dhi_sh_q, rx_data};
        state_d   = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A byte arriving on the expiry cycle wins: the check requires !rx_valid.
    if (state_q != S_IDLE && !rx_valid && to_cnt_q == TO_SIZE'(TIMEOUT_CLKS - 1)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end

    err_count_d = err_count_q;
    if (frame_err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed cases plus random byte streams
// compared against a frame-queue reference model.
module tb_uart_cmd_parser;
  localparam int T = 64;
`ifdef CMD_PARSER_CHKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_en, frame_err, busy;
  logic [7:0]  wr_addr, err_count;
  logic [15:0] wr_data;

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: bytes of the frame in progress and clocks since the last byte.
  logic [7:0]  frame[$];
  int          silence = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_wr = 1'b0, m_err = 1'b0;
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [7:0] d);
    logic good;
    m_wr  = 1'b0;
    m_err = 1'b0;
    if (!rst) begin
      frame.delete();
      silence = 0;
      m_addr  = 8'h00;
      m_data  = 16'h0000;
      m_cnt   = 0;
    end else if (v) begin
      silence = 0;
      if (frame.size() == 0) begin
        if (d == 8'hA5) frame.push_back(d);
      end else begin
        frame.push_back(d);
        if (frame.size() == FLEN) begin
`ifdef CMD_PARSER_CHKSUM_EN
          good = ((frame[1] ^ frame[2] ^ frame[3]) == frame[4]);
`else
          good = 1'b1;
`endif
          if (good) begin
            m_wr   = 1'b1;
            m_addr = frame[1];
            m_data = {frame[2], frame[3]};
          end else begin
            m_err = 1'b1;
          end
          frame.delete();
        end
      end
    end else if (frame.size() > 0) begin
      silence++;
      if (silence == T) begin
        m_err = 1'b1;
        frame.delete();
        silence = 0;
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".wr_en"},     32'(wr_en),     32'(m_wr));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_err));
    check({tag, ".wr_addr"},   32'(wr_addr),   32'(m_addr));
    check({tag, ".wr_data"},   32'(wr_data),   32'(m_data));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
    check({tag, ".busy"},      32'(busy),      32'(frame.size() > 0));
    check({tag, ".excl"},      32'(wr_en & frame_err), 32'd0);
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(rst_n, v, d);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input string tag, input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] ck);
    step(tag, 1'b1, 8'hA5);
    step(tag, 1'b1, a);
    step(tag, 1'b1, dh);
    step(tag, 1'b1, dl);
`ifdef CMD_PARSER_CHKSUM_EN
    step(tag, 1'b1, ck);
`else
    if (ck == 8'h00) tests += 0;
`endif
  endtask

  initial begin
    logic [7:0] a, dh, dl;
    // Reset state
    step("reset", 1'b0, 8'h00);
    step("reset", 1'b0, 8'h00);
    check("reset.wr_addr", 32'(wr_addr), 32'h0);
    check("reset.err_count", 32'(err_count), 32'h0);
    rst_n = 1'b1;
    step("idle", 1'b0, 8'h00);

    // Good frame
`ifdef CMD_PARSER_CHKSUM_EN
    send_frame("good", 8'h12, 8'h34, 8'h56, 8'h70);
    check("good.wr_en", 32'(wr_en), 32'h1);
    check("good.wr_addr", 32'(wr_addr), 32'h12);
    check("good.wr_data", 32'(wr_data), 32'h3456);
    step("good.after", 1'b0, 8'h00);
    check("good.pulse1", 32'(wr_en), 32'h0);

    // Bad checksum: outputs hold, one error
    send_frame("badck", 8'h12, 8'h34, 8'h56, 8'h00);
    check("badck.frame_err", 32'(frame_err), 32'h1);
    check("badck.wr_en", 32'(wr_en), 32'h0);
    check("badck.hold", 32'(wr_data), 32'h3456);
    check("badck.err_count", 32'(err_count), 32'h1);
`else
    send_frame("good", 8'h01, 8'hBE, 8'hEF, 8'h00);
    check("good.wr_en", 32'(wr_en), 32'h1);
    check("good.wr_addr", 32'(wr_addr), 32'h01);
    check("good.wr_data", 32'(wr_data), 32'hBEEF);
    step("good.after", 1'b0, 8'h00);
    check("good.pulse1", 32'(wr_en), 32'h0);
`endif

    // Timeout: error exactly T clocks after the last byte
    step("to", 1'b1, 8'hA5);
    step("to", 1'b1, 8'h12);
    idle("to.wait", T - 1);
    check("to.before", 32'(frame_err), 32'h0);
    check("to.busy_before", 32'(busy), 32'h1);
    step("to.expire", 1'b0, 8'h00);
    check("to.frame_err", 32'(frame_err), 32'h1);
    check("to.busy", 32'(busy), 32'h0);
    send_frame("to.next", 8'h21, 8'h43, 8'h65, 8'h21 ^ 8'h43 ^ 8'h65);
    check("to.next.wr_addr", 32'(wr_addr), 32'h21);

    // Byte coincident with expiry wins
    step("coin", 1'b1, 8'hA5);
    step("coin", 1'b1, 8'h30);
    idle("coin.wait", T - 1);
    step("coin.byte", 1'b1, 8'h40);
    check("coin.no_err", 32'(frame_err), 32'h0);
    check("coin.busy", 32'(busy), 32'h1);
    step("coin", 1'b1, 8'h50);
`ifdef CMD_PARSER_CHKSUM_EN
    step("coin", 1'b1, 8'h30 ^ 8'h40 ^ 8'h50);
`endif
    check("coin.wr_data", 32'(wr_data), 32'h4050);

    // Noise before a frame, SYNC value as ADDR, back-to-back frame
    step("noise", 1'b1, 8'h00);
    step("noise", 1'b1, 8'hFF);
    step("noise", 1'b1, 8'h13);
    check("noise.busy", 32'(busy), 32'h0);
    send_frame("noise.frame", 8'hA5, 8'h01, 8'h02, 8'hA5 ^ 8'h01 ^ 8'h02);
    check("noise.wr_addr", 32'(wr_addr), 32'hA5);
    send_frame("b2b", 8'h77, 8'h88, 8'h99, 8'h77 ^ 8'h88 ^ 8'h99);
    check("b2b.wr_en", 32'(wr_en), 32'h1);
    check("b2b.wr_addr", 32'(wr_addr), 32'h77);

    // Reset mid-frame
    step("rst", 1'b1, 8'hA5);
    step("rst", 1'b1, 8'h12);
    step("rst", 1'b1, 8'h34);
    rst_n = 1'b0;
    step("rst.low", 1'b0, 8'h00);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.wr_data", 32'(wr_data), 32'h0);
    rst_n = 1'b1;
    send_frame("rst.next", 8'h5A, 8'hC3, 8'h3C, 8'h5A ^ 8'hC3 ^ 8'h3C);
    check("rst.next.wr_data", 32'(wr_data), 32'hC33C);

    // Randomised stream
    for (int it = 0; it < 200; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
      if (kind < 5) begin
        step("rnd", 1'b1, 8'hA5);
        step("rnd", 1'b1, a);
        idle("rnd.gap", $urandom_range(0, 3));
        step("rnd", 1'b1, dh);
        idle("rnd.gap", (kind == 0) ? T - 1 : $urandom_range(0, 2));
        step("rnd", 1'b1, dl);
`ifdef CMD_PARSER_CHKSUM_EN
        step("rnd", 1'b1, (kind == 1) ? 8'($urandom) : (a ^ dh ^ dl));
`endif
      end else if (kind < 8) begin
        step("rnd.byte", 1'b1, ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom));
      end else begin
        idle("rnd.idle", (kind == 9) ? $urandom_range(T - 2, T + 2) : $urandom_range(1, 5));
      end
    end
    idle("rnd.flush", T + 1);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
`ifdef CMD_PARSER_CHKSUM_EN
      send_frame("sat", 8'h01, 8'h02, 8'h03, 8'hFF);
`else
      step("sat", 1'b1, 8'hA5);
      idle("sat.wait", T);
`endif
    end
    check("sat.err_count", 32'(err_count), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
